// File: rtl/hls_fmul_arbiter.sv
// ---------------------------------------------------------------------------
// hls_fmul_arbiter
//
// Shares a single pipelined FP32 multiplier between NREQ HLS operator call
// sites. Each requester raises req with its operands and receives a one-cycle
// ack when the product is on the shared out bus. Issue is round-robin, at most
// one new multiply per cycle, and fully pipelined; a tag pipeline that matches
// the multiplier latency carries the requester index alongside each product
// so the ack lands on the right requester.
//
// Parameters:
//   NREQ     number of requesters (2..16)
//   MUL_LAT  clock edges from a mul_a/mul_b change to a valid mul_res (>=1)
//
// Ports:
//   clk      rising-edge clock
//   reset    asynchronous active-low reset
//   req      per-requester request level
//   p0, p1   packed operands, requester i at [32*i+31:32*i]
//   ack      per-requester one-cycle result strobe (one-hot or zero)
//   out      shared result bus, meaningful only while some ack bit is 1
//   mul_a    registered operand A to the multiplier
//   mul_b    registered operand B to the multiplier
//   mul_res  multiplier result
//   idle     1 when no operation is in flight
// ---------------------------------------------------------------------------
module hls_fmul_arbiter #(
    parameter int NREQ    = 4,
    parameter int MUL_LAT = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [32*NREQ-1:0]   p0,
    input  logic [32*NREQ-1:0]   p1,
    output logic [NREQ-1:0]      ack,
    output logic [31:0]          out,
    output logic [31:0]          mul_a,
    output logic [31:0]          mul_b,
    input  logic [31:0]          mul_res,
    output logic                 idle
);

    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]    busy;
    logic [NREQ-1:0]    elig;
    logic [NREQ-1:0]    gnt_onehot;
    logic [NREQ-1:0]    ack_nxt;
    logic               gnt_valid;
    logic [IDW-1:0]     gnt_id;
    logic [IDW-1:0]     rr;

    // In-flight tags: stage 0 is written on the issue edge, the last stage
    // lines up with mul_res one edge before it becomes valid, so ack is
    // registered from it and coincides with the product on out.
    logic [MUL_LAT-1:0] tag_v;
    logic [IDW-1:0]     tag_id [MUL_LAT];

    // A requester in its ack cycle still has busy set; masking ack as well
    // keeps the "no re-grant in the ack cycle" rule explicit.
    assign elig = req & ~busy & ~ack;

    // Round-robin search starting at rr, first eligible index wins.
    always_comb begin
        int unsigned idx;
        idx        = 0;
        gnt_valid  = 1'b0;
        gnt_id     = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = (32'(rr) + k) % NREQ;
            if (!gnt_valid && elig[idx[IDW-1:0]]) begin
                gnt_valid = 1'b1;
                gnt_id    = idx[IDW-1:0];
            end
        end
        gnt_onehot = '0;
        if (gnt_valid) begin
            gnt_onehot[gnt_id] = 1'b1;
        end
    end

    always_comb begin
        ack_nxt = '0;
        if (tag_v[MUL_LAT-1]) begin
            ack_nxt[tag_id[MUL_LAT-1]] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr    <= '0;
            busy  <= '0;
            ack   <= '0;
            mul_a <= '0;
            mul_b <= '0;
            tag_v <= '0;
            for (int unsigned s = 0; s < MUL_LAT; s++) begin
                tag_id[s] <= '0;
            end
        end else begin
            ack  <= ack_nxt;
            busy <= (busy & ~ack) | gnt_onehot;

            tag_v[0]  <= gnt_valid;
            tag_id[0] <= gnt_id;
            for (int unsigned s = 1; s < MUL_LAT; s++) begin
                tag_v[s]  <= tag_v[s-1];
                tag_id[s] <= tag_id[s-1];
            end

            // Operand registers hold when nothing is issued.
            if (gnt_valid) begin
                mul_a <= p0[32*gnt_id +: 32];
                mul_b <= p1[32*gnt_id +: 32];
                rr    <= (32'(gnt_id) == NREQ - 1) ? '0 : gnt_id + 1'b1;
            end
        end
    end

    assign out  = mul_res;
    assign idle = ~|busy;

endmodule
